// File: rtl/program_sequencer.sv
// Runs one test program: fetches instructions from ROM, issues them to the execute unit,
// follows jumps/halt under a step budget, then checks the out channel against expected values.
module program_sequencer #(
    parameter int unsigned AddrWidth          = 8,
    parameter int unsigned NCode              = 256,
    parameter int unsigned InstWidth          = 32,
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned OutAddrWidth       = 4,
    parameter int unsigned NOutCheck          = 3,
    parameter int unsigned StepWidth          = 16,
    parameter int unsigned MaxSteps           = 1000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run,
    output logic [AddrWidth-1:0]          codeAddr,
    input  logic [InstWidth-1:0]          codeData,
    output logic                          exValid,
    input  logic                          exReady,
    output logic [InstWidth-1:0]          exInst,
    output logic [AddrWidth-1:0]          exIp,
    input  logic                          exDone,
    input  logic [AddrWidth-1:0]          exNextIp,
    input  logic                          exHalt,
    output logic [OutAddrWidth-1:0]       chkAddr,
    input  logic [MemoryElementWidth-1:0] outData,
    input  logic [MemoryElementWidth-1:0] expData,
    output logic                          running,
    output logic                          finished,
    output logic                          success,
    output logic                          timedOut,
    output logic [StepWidth-1:0]          steps
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StLoad, StIssue, StExec, StChkAddr, StChkCmp, StDone
    } state_e;

    localparam logic [OutAddrWidth-1:0] ChkLast =
        OutAddrWidth'((NOutCheck == 0) ? 0 : NOutCheck - 1);
    localparam logic [StepWidth-1:0] StepMax = '1;

    state_e                  state_q, state_d;
    logic [AddrWidth-1:0]    ip_q, ip_d;
    logic [StepWidth-1:0]    steps_q, steps_d;
    logic [OutAddrWidth-1:0] chk_addr_q, chk_addr_d;
    logic [InstWidth-1:0]    inst_q, inst_d;
    logic [AddrWidth-1:0]    inst_ip_q, inst_ip_d;
    logic                    timed_out_q, timed_out_d;
    logic                    fail_q, fail_d;
    logic                    past_end;
    logic                    budget_hit;

    assign past_end   = (32'(exNextIp) >= NCode);
    assign budget_hit = ((32'(steps_q) + 32'd1) == MaxSteps);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            ip_q        <= '0;
            steps_q     <= '0;
            chk_addr_q  <= '0;
            inst_q      <= '0;
            inst_ip_q   <= '0;
            timed_out_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            steps_q     <= steps_d;
            chk_addr_q  <= chk_addr_d;
            inst_q      <= inst_d;
            inst_ip_q   <= inst_ip_d;
            timed_out_q <= timed_out_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        steps_d     = steps_q;
        chk_addr_d  = chk_addr_q;
        inst_d      = inst_q;
        inst_ip_d   = inst_ip_q;
        timed_out_d = timed_out_q;
        fail_d      = fail_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (run) begin
                    state_d     = StFetch;
                    ip_d        = '0;
                    steps_d     = '0;
                    chk_addr_d  = '0;
                    timed_out_d = 1'b0;
                    fail_d      = 1'b0;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                inst_d    = codeData;
                inst_ip_d = ip_q;
                state_d   = StIssue;
            end
            StIssue: if (exReady) state_d = StExec;
            StExec: begin
                if (exDone) begin
                    steps_d = (steps_q == StepMax) ? steps_q : steps_q + 1'b1;
                    // Halt/end-of-program wins over the budget on the final step.
                    if (exHalt || past_end) begin
                        state_d = (NOutCheck == 0) ? StDone : StChkAddr;
                    end else if (budget_hit) begin
                        timed_out_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        ip_d    = exNextIp;
                        state_d = StFetch;
                    end
                end
            end
            StChkAddr: state_d = StChkCmp;
            StChkCmp: begin
                if (outData != expData) fail_d = 1'b1;
                if (chk_addr_q == ChkLast) begin
                    state_d = StDone;
                end else begin
                    chk_addr_d = chk_addr_q + 1'b1;
                    state_d    = StChkAddr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        exValid  = (state_q == StIssue);
        running  = (state_q != StIdle) && (state_q != StDone);
        finished = (state_q == StDone);
        success  = (state_q == StDone) && !fail_q && !timed_out_q;
        timedOut = timed_out_q;
        steps    = steps_q;
        codeAddr = ip_q;
        chkAddr  = chk_addr_q;
        exInst   = inst_q;
        exIp     = inst_ip_q;
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: the bench plays ROMs and a tiny-ISA execute unit with random
// handshake timing, and compares each run against an instruction-level program interpreter.
module tb_program_sequencer;

    localparam int NCODE  = 256;
    localparam int NCHK   = 3;
    localparam int MAXS   = 1000;
    localparam int BUDGET = 20000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  codeAddr;
    logic [31:0] codeData;
    logic        exValid;
    logic        exReady = 1'b0;
    logic [31:0] exInst;
    logic [7:0]  exIp;
    logic        exDone = 1'b0;
    logic [7:0]  exNextIp = 8'd0;
    logic        exHalt = 1'b0;
    logic [3:0]  chkAddr;
    logic [11:0] outData;
    logic [11:0] expData;
    logic        running, finished, success, timedOut;
    logic [15:0] steps;

    program_sequencer #(
        .AddrWidth(8), .NCode(NCODE), .InstWidth(32), .MemoryElementWidth(12),
        .OutAddrWidth(4), .NOutCheck(NCHK), .StepWidth(16), .MaxSteps(MAXS)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .codeAddr(codeAddr), .codeData(codeData),
        .exValid(exValid), .exReady(exReady), .exInst(exInst), .exIp(exIp),
        .exDone(exDone), .exNextIp(exNextIp), .exHalt(exHalt), .chkAddr(chkAddr),
        .outData(outData), .expData(expData), .running(running), .finished(finished),
        .success(success), .timedOut(timedOut), .steps(steps)
    );

    always #5 clock = ~clock;

    logic [31:0] rom [NCODE];
    logic [11:0] out_mem [16];
    logic [11:0] exp_mem [16];
    int total = 0;
    int bad = 0;

    // ISA: [31:28] op (0 mov imm, 1 logical not, 2 out, 3 jmp imm), [27] halt, [11:0] imm
    function automatic logic [31:0] mk(input int op, input bit h, input int imm);
        logic [3:0]  o;
        logic [11:0] m;
        o = op[3:0];
        m = imm[11:0];
        return {o, h, 15'd0, m};
    endfunction

    function automatic void isa_step(input logic [31:0] inst, input int ip, input int acc_in,
                                     output int acc_out, output bit is_out, output int nip,
                                     output bit halt);
        acc_out = acc_in;
        is_out  = 1'b0;
        nip     = ip + 1;
        halt    = inst[27];
        case (inst[31:28])
            4'd0: acc_out = int'(inst[11:0]);
            4'd1: acc_out = (acc_in == 0) ? 1 : 0;
            4'd2: is_out = 1'b1;
            4'd3: nip = int'(inst[11:0]);
            default: ;
        endcase
    endfunction

    always @(posedge clock) begin
        codeData <= rom[codeAddr];
        outData  <= out_mem[chkAddr];
        expData  <= exp_mem[chkAddr];
    end

    // Execute-unit environment, acting half a cycle away from the DUT's clock edge.
    int          env_acc = 0;
    int          env_oc = 0;
    int          hold_cnt = 0;
    int          dmax = 2;
    bit          pend = 1'b0;
    int          dcnt = 0;
    logic [31:0] p_inst;
    int          p_ip;
    int          acc_trace[$];

    always @(negedge clock) begin
        int nacc, nip;
        bit is_out, hlt;
        #1;
        exDone   = 1'b0;
        exHalt   = 1'($urandom_range(0, 1));
        exNextIp = 8'($urandom);
        if (reset) begin
            pend    = 1'b0;
            exReady = 1'($urandom_range(0, 1));
        end else begin
            if (pend) begin
                if (dcnt == 0) begin
                    pend = 1'b0;
                    isa_step(p_inst, p_ip, env_acc, nacc, is_out, nip, hlt);
                    if (is_out && env_oc < 16) begin
                        out_mem[env_oc] = nacc[11:0];
                        env_oc++;
                    end
                    env_acc  = nacc;
                    exDone   = 1'b1;
                    exNextIp = nip[7:0];
                    exHalt   = hlt;
                end else begin
                    dcnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                exDone = 1'b1;  // stray pulse while nothing is outstanding
            end
            if (hold_cnt > 0 && exValid) begin
                exReady = 1'b0;
                hold_cnt--;
            end else begin
                exReady = ($urandom_range(0, 3) != 0);
            end
            if (exValid && exReady) begin
                pend   = 1'b1;
                dcnt   = int'($urandom_range(0, dmax));
                p_inst = exInst;
                p_ip   = int'(exIp);
                acc_trace.push_back(int'(exIp));
            end
        end
    end

    // Reference model: interprets the program directly.
    int          m_trace[$];
    logic [11:0] m_outs [16];
    int          m_steps;
    bit          m_to, m_succ;
    bit          saw3;

    task automatic model_run();
        int ip, acc, oc, nacc, nip;
        bit is_out, hlt;
        ip = 0; acc = 0; oc = 0; m_steps = 0; m_to = 1'b0;
        m_trace.delete();
        for (int i = 0; i < 16; i++) m_outs[i] = '0;
        forever begin
            m_trace.push_back(ip);
            isa_step(rom[ip], ip, acc, nacc, is_out, nip, hlt);
            if (is_out && oc < 16) begin
                m_outs[oc] = nacc[11:0];
                oc++;
            end
            acc = nacc;
            m_steps++;
            if (hlt || nip >= NCODE) break;
            if (m_steps == MAXS) begin
                m_to = 1'b1;
                break;
            end
            ip = nip;
        end
        m_succ = !m_to;
        for (int k = 0; k < NCHK; k++) if (m_outs[k] != exp_mem[k]) m_succ = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < NCODE; i++) rom[i] = mk(0, 1'b1, 0);
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    endtask

    task automatic load_not(input logic [11:0] e1);
        clear_rom();
        rom[0] = mk(0, 1'b0, 3);
        rom[1] = mk(2, 1'b0, 0);
        rom[2] = mk(1, 1'b0, 0);
        rom[3] = mk(2, 1'b0, 0);
        rom[4] = mk(1, 1'b0, 0);
        rom[5] = mk(2, 1'b1, 0);
        exp_mem[0] = 12'd3;
        exp_mem[1] = e1;
        exp_mem[2] = 12'd1;
    endtask

    task automatic start_run(output logic fin_after);
        env_acc = 0;
        env_oc  = 0;
        saw3    = 1'b0;
        acc_trace.delete();
        for (int i = 0; i < 16; i++) out_mem[i] = '0;
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        #2;
        fin_after = finished;
        run = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clock);
            #2;
            if (running && codeAddr == 8'd3) saw3 = 1'b1;
            if (finished) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic trace_match(output bit ok);
        ok = (acc_trace.size() == m_trace.size());
        if (ok) foreach (m_trace[i]) if (acc_trace[i] != m_trace[i]) ok = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #2;
        total++;
        if ({exValid, running, finished, success, timedOut} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {exValid, running, finished, success, timedOut});
        end
        total++;
        if (steps !== 16'd0) begin
            bad++;
            $display("FAIL reset_steps: got %0d want 0", steps);
        end
        total++;
        if ({chkAddr, codeAddr} !== 12'd0) begin
            bad++;
            $display("FAIL reset_addrs: chkAddr=%0d codeAddr=%0d want 0 0", chkAddr, codeAddr);
        end
        reset = 1'b0;
    endtask

    task automatic test_not_program(input logic [11:0] e1, input logic want_succ);
        logic fa;
        bit ok, tr;
        load_not(e1);
        model_run();
        start_run(fa);
        total++;
        if (fa !== 1'b0) begin
            bad++;
            $display("FAIL not_restart_finished: got %b want 0", fa);
        end
        wait_done(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL not_finish: finished=%b want 1 within %0d cycles", finished, BUDGET);
        end
        total++;
        if ({success, timedOut} !== {want_succ, 1'b0}) begin
            bad++;
            $display("FAIL not_result: success=%b timedOut=%b want %b 0",
                     success, timedOut, want_succ);
        end
        total++;
        if (steps !== 16'd6) begin
            bad++;
            $display("FAIL not_steps: got %0d want 6", steps);
        end
        trace_match(tr);
        total++;
        if (!tr) begin
            bad++;
            $display("FAIL not_trace: got %0d accepts want %0d", acc_trace.size(), m_trace.size());
        end
    endtask

    task automatic test_issue_hold();
        logic fa;
        bit ok, tr, found;
        load_not(12'd0);
        model_run();
        hold_cnt = 3;
        start_run(fa);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            #2;
            found = exValid;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL hold_issue_seen: exValid=%b want 1", exValid);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clock);
                #2;
            end
            total++;
            if (exValid !== 1'b1 || exInst !== rom[0] || exIp !== 8'd0 || acc_trace.size() != 0)
            begin
                bad++;
                $display("FAIL hold_stable[%0d]: valid=%b inst=%h ip=%0d acc=%0d want 1 %h 0 0",
                         k, exValid, exInst, exIp, acc_trace.size(), rom[0]);
            end
        end
        wait_done(ok);
        trace_match(tr);
        total++;
        if (!ok || !tr || steps !== 16'd6 || success !== 1'b1) begin
            bad++;
            $display("FAIL hold_result: done=%b trace_ok=%b steps=%0d success=%b want 1 1 6 1",
                     ok, tr, steps, success);
        end
    endtask

    task automatic test_halt_at_2();
        logic fa;
        bit ok, tr;
        clear_rom();
        rom[0] = mk(0, 1'b0, 1);
        rom[1] = mk(1, 1'b0, 0);
        rom[2] = mk(1, 1'b1, 0);
        rom[3] = mk(2, 1'b1, 0);
        model_run();
        start_run(fa);
        wait_done(ok);
        total++;
        if (!ok || steps !== 16'd3) begin
            bad++;
            $display("FAIL halt_steps: done=%b steps=%0d want 1 3", ok, steps);
        end
        trace_match(tr);
        total++;
        if (!tr || saw3) begin
            bad++;
            $display("FAIL halt_no_fetch3: trace_ok=%b saw_ip3=%b want 1 0", tr, saw3);
        end
        total++;
        if (chkAddr !== 4'(NCHK - 1) || success !== m_succ) begin
            bad++;
            $display("FAIL halt_check: chkAddr=%0d success=%b want %0d %b",
                     chkAddr, success, NCHK - 1, m_succ);
        end
    endtask

    task automatic test_reset_in_exec();
        logic fa;
        bit ok, tr, found;
        load_not(12'd0);
        dmax = 6;
        start_run(fa);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            #2;
            found = (acc_trace.size() == 2);
        end
        @(negedge clock);
        total++;
        if (!found || !running || exValid) begin
            bad++;
            $display("FAIL rst_exec_reach: found=%b running=%b exValid=%b want 1 1 0",
                     found, running, exValid);
        end
        reset = 1'b1;
        @(negedge clock);
        #2;
        total++;
        if ({exValid, running, finished, success, timedOut, steps, chkAddr, codeAddr} !== '0)
        begin
            bad++;
            $display("FAIL rst_exec_clear: v=%b r=%b f=%b s=%b t=%b steps=%0d chk=%0d ca=%0d",
                     exValid, running, finished, success, timedOut, steps, chkAddr, codeAddr);
        end
        reset = 1'b0;
        dmax = 2;
        model_run();
        start_run(fa);
        wait_done(ok);
        trace_match(tr);
        total++;
        if (!ok || !tr || steps !== 16'd6 || success !== 1'b1) begin
            bad++;
            $display("FAIL rst_exec_rerun: done=%b trace_ok=%b steps=%0d success=%b want 1 1 6 1",
                     ok, tr, steps, success);
        end
    endtask

    task automatic test_timeout();
        logic fa;
        bit ok, tr;
        clear_rom();
        rom[0] = mk(3, 1'b0, 0);
        model_run();
        start_run(fa);
        wait_done(ok);
        total++;
        if (!ok || timedOut !== 1'b1 || success !== 1'b0) begin
            bad++;
            $display("FAIL timeout_flags: done=%b timedOut=%b success=%b want 1 1 0",
                     ok, timedOut, success);
        end
        total++;
        if (steps !== 16'(MAXS)) begin
            bad++;
            $display("FAIL timeout_steps: got %0d want %0d", steps, MAXS);
        end
        trace_match(tr);
        total++;
        if (chkAddr !== 4'd0 || !tr) begin
            bad++;
            $display("FAIL timeout_chk: chkAddr=%0d trace_ok=%b want 0 1", chkAddr, tr);
        end
    endtask

    task automatic test_random();
        logic fa;
        bit ok, tr;
        int len, op, k;
        for (int it = 0; it < 10; it++) begin
            clear_rom();
            len = int'($urandom_range(3, 16));
            for (int i = 0; i < len - 1; i++) begin
                op = int'($urandom_range(0, 3));
                if (op == 3) rom[i] = mk(3, 1'b0, int'($urandom_range(i + 1, len - 1)));
                else rom[i] = mk(op, 1'b0, int'($urandom_range(0, 4095)));
            end
            rom[len - 1] = mk(2, 1'b1, 0);
            model_run();
            for (int j = 0; j < NCHK; j++) exp_mem[j] = m_outs[j];
            if ($urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, NCHK - 1));
                exp_mem[k] = exp_mem[k] ^ 12'(1 << $urandom_range(0, 11));
            end
            model_run();
            start_run(fa);
            wait_done(ok);
            trace_match(tr);
            total++;
            if (!ok || fa !== 1'b0 || !tr) begin
                bad++;
                $display("FAIL rand[%0d]_flow: done=%b fin_after_run=%b trace_ok=%b want 1 0 1",
                         it, ok, fa, tr);
            end
            total++;
            if (success !== m_succ || timedOut !== 1'b0 || steps !== 16'(m_steps) ||
                chkAddr !== 4'(NCHK - 1)) begin
                bad++;
                $display("FAIL rand[%0d]_result: s=%b t=%b steps=%0d chk=%0d want %b 0 %0d %0d",
                         it, success, timedOut, steps, chkAddr, m_succ, m_steps, NCHK - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_not_program(12'd0, 1'b1);
        test_not_program(12'd5, 1'b0);
        test_issue_hold();
        test_halt_at_2();
        test_reset_in_exec();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
